// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// The minimum effective divisor is 2, so every period has a low and a high phase.
package clk_div_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DIV_MIN   = 2;

  typedef logic [CNT_W_DEF-1:0] div_t;

  function automatic div_t eff_div(input div_t value);
    return (value < div_t'(DIV_MIN)) ? div_t'(DIV_MIN) : value;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadow/active divisor pair, tick strobe and divided clock.
// A new divisor takes effect only at a period boundary: wrap, sync, or any edge while disabled.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             we,
  input  logic [CNT_W-1:0] wr_val,
  output logic             tick,
  output logic             clk_div,
  output logic [CNT_W-1:0] div_cur
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  logic             pending;

  logic [CNT_W-1:0] d_eff;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] shadow_next;
  logic [CNT_W-1:0] active_next;
  logic             pending_next;
  logic             wrap;
  logic             boundary;
  logic             clk_div_next;

  always_comb begin
    d_eff        = (active < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : active;
    half         = d_eff >> 1;
    // sync outranks the natural wrap, so an aborted period never produces a tick
    wrap         = en && !sync && (cnt >= d_eff - CNT_W'(1));
    boundary     = !en || sync || wrap;
    shadow_next  = we ? wr_val : shadow;
    pending_next = pending | we;
    active_next  = active;
    if (boundary) begin
      active_next  = shadow_next;
      pending_next = 1'b0;
    end
    cnt_next = '0;
    if (en && !sync && !wrap) begin
      cnt_next = cnt + CNT_W'(1);
    end
    // compare against the divisor of the period in progress; cnt_next is 0 on any boundary
    clk_div_next = en && (cnt_next >= half);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      active  <= CNT_W'(DEFAULT_DIV);
      shadow  <= CNT_W'(DEFAULT_DIV);
      pending <= 1'b0;
      tick    <= 1'b0;
      clk_div <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      active  <= active_next;
      shadow  <= shadow_next;
      pending <= pending_next;
      tick    <= wrap;
      clk_div <= clk_div_next;
    end
  end

  assign div_cur = active;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: write decode, sync fan-out and output packing around clk_div_ch.
// div_we is a single-cycle strobe with no back-pressure; out-of-range div_sel values are dropped.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NUM_CH      = 2,
  parameter  int CNT_W       = 16,
  parameter  int DEFAULT_DIV = 100,
  localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  input  logic                    div_we,
  input  logic [SEL_W-1:0]        div_sel,
  input  logic [CNT_W-1:0]        div_val,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       clk_div_o,
  output logic [NUM_CH*CNT_W-1:0] div_cur_o
);

  logic [NUM_CH-1:0] ch_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ch_we[i] = div_we && (div_sel == SEL_W'(i));

    clk_div_ch #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .sync   (sync),
      .we     (ch_we[i]),
      .wr_val (div_val),
      .tick   (tick_o[i]),
      .clk_div(clk_div_o[i]),
      .div_cur(div_cur_o[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock divider for the servo/SPI steering design.
- Each channel derives, from the single system clock, a 1-cycle strobe (`tick_o`) and a registered divided square wave (`clk_div_o`).
- Typical consumers: SPI SCLK/bit-rate generation, and the servo PWM period/resolution base.
- Divisors are runtime-programmable with glitch-free update; all channels can be phase-aligned with one sync pulse.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8).
- CNT_W, 16, width of divisor and counter per channel.
- DEFAULT_DIV, 100, divisor loaded into every channel at reset; must be >= 2 and < 2**CNT_W.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous active-low reset; asserts asynchronously, released synchronously by upstream logic.
- en  in  NUM_CH  per-channel run enable.
- sync  in  1  single-cycle pulse; restarts the period of all channels at count 0.
- div_we  in  1  divisor write strobe.
- div_sel  in  $clog2(NUM_CH) (min 1)  channel addressed by div_we.
- div_val  in  CNT_W  new divisor value.
- tick_o  out  NUM_CH  one-cycle strobe per completed period.
- clk_div_o  out  NUM_CH  divided clock, period D cycles.
- div_cur_o  out  NUM_CH*CNT_W  active divisor per channel (channel i at bits [i*CNT_W +: CNT_W]).

Behaviour:
- Reset (rst=0):
  - cnt=0, active divisor=DEFAULT_DIV, shadow divisor=DEFAULT_DIV, pending=0.
  - tick_o=0, clk_div_o=0.
- Effective divisor D = max(active, 2). Writes of 0 or 1 are stored but behave as 2.
- Counter per channel, while en[i]=1:
  - cnt increments each edge.
  - When cnt==D-1 it wraps to 0.
- tick_o[i] (registered):
  - Set on the edge where cnt wraps D-1->0, cleared on the next edge.
  - Asserted exactly 1 cycle in every D.
  - First tick occurs at the D-th edge with en[i] sampled high.
- clk_div_o[i] (registered):
  - Loaded each edge with (cnt_next >= floor(D/2)).
  - Period is D cycles; high time is ceil(D/2); low phase comes first after the period start.
- Disabled (en[i]=0):
  - cnt held at 0; tick_o[i]=0 and clk_div_o[i]=0 from the next edge.
  - Re-enabling starts a fresh period from cnt=0.
  - No partial tick on disable.
- Divisor write (div_we=1):
  - div_val goes into channel div_sel's shadow and sets pending.
  - If the channel is disabled, shadow->active on the same edge; pending stays 0.
  - If enabled, shadow->active on the wrap edge (period boundary) only; no truncated or stretched period.
  - div_sel >= NUM_CH: write ignored.
- Repeated writes before a boundary: last write wins.
- Write coincident with the wrap edge: the new value is applied at that edge; the next period uses it.
- sync=1:
  - Every enabled channel sets cnt=0 and applies any pending shadow.
  - tick_o is not asserted for the aborted period.
  - clk_div_o is loaded per the cnt_next=0 rule (low).
  - sync has priority over wrap and over en rising.
  - sync with div_we on the same edge: the written value is applied immediately.
- Reset mid-operation: all state returns to reset values asynchronously; outputs are low within the reset assertion.
- div_cur_o reflects the active (not shadow) divisor, registered.
- No combinational paths from inputs to outputs.

Decomposition:
- Package clk_div_pkg:
  - CNT_W_DEF and DIV_MIN=2 constants.
  - Function eff_div(value) returning max(value, DIV_MIN).
  - Typedef div_t (logic [CNT_W_DEF-1:0]).
- Sub-module clk_div_ch:
  - One channel: counter, shadow/active divisor, pending flag, tick/clk_div registers.
  - Instantiated NUM_CH times by a generate loop in clk_div_multi.
  - Top level holds only write decode, sync fan-out and output packing.

Test Plan:
- Reset, en=2'b01, default divisor 100 -> tick_o[0] first high at the 100th enabled edge, then every 100 cycles; clk_div_o[0] low 50 / high 50; channel 1 stays 0.
- Write div_val=7 to ch0 mid-period while enabled -> current 100-cycle period completes unchanged; then period 7, high 4 / low 3; div_cur_o updates at the boundary edge.
- Write div_val=0 and 1 to a disabled ch1, then enable -> behaves as D=2: tick every 2 cycles; clk_div_o toggles each cycle.
- Both channels enabled with D=10 and D=15 at unrelated phases; pulse sync -> both cnt=0; next ticks 10 and 15 cycles after sync; no tick for the aborted periods.
- Drop en[0] at cnt=5, re-enable 20 cycles later -> outputs 0 while disabled; first tick D edges after re-enable.
- Assert rst low mid-period with pending write -> outputs 0 immediately; after release, divisor=DEFAULT_DIV and the pending value is discarded.
